// File: rtl/lcd_bus_writer.sv
// HD44780-style LCD write engine: one byte per valid/ready handshake, 8-bit or 4-bit bus.
// Optional LCD_LONG_CMD_EN: clear/return-home instructions wait LONG_CYC instead of EXEC_CYC.
`timescale 1ns/1ps
module lcd_bus_writer #(
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC    = 12,
  parameter int HOLD_CYC  = 2,
  parameter int EXEC_CYC  = 2000,
  parameter int LONG_CYC  = 76000,
  parameter int BUS_4BIT  = 0
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iVALID,
  output logic       oREADY,
  input  logic       iRS,
  input  logic [7:0] iDATA,
  output logic       oDONE,
  output logic       oBUSY,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, EN_CYC), max2(HOLD_CYC, EXEC_CYC)), LONG_CYC);
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LAST    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] EXEC_LAST  = CW'(EXEC_CYC - 1);
`ifdef LCD_LONG_CMD_EN
  localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_CYC - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_EXEC  = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_nx;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] exec_last_r;
  logic [3:0]    low_nib_data_r;
  logic          low_nib_sent_r;
  logic          accept_s;
  logic          nib_load_s;

  assign accept_s = iVALID && oREADY;
  assign LCD_RW   = 1'b0;

  // State and phase counter registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
    end
  end

  // Next-state logic: every phase ends on its last count and the counter restarts at 0.
  always_comb begin
    state_nx   = state_r;
    cnt_nx     = cnt_r + CW'(1);
    nib_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nx = '0;
        if (accept_s) begin
          state_nx = ST_SETUP;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          state_nx = ST_PULSE;
          cnt_nx   = '0;
        end else begin
          state_nx = ST_SETUP;
        end
      end
      ST_PULSE: begin
        if (cnt_r == EN_LAST) begin
          state_nx = ST_HOLD;
          cnt_nx   = '0;
        end else begin
          state_nx = ST_PULSE;
        end
      end
      ST_HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          cnt_nx = '0;
          if ((BUS_4BIT != 0) && !low_nib_sent_r) begin
            state_nx   = ST_SETUP;
            nib_load_s = 1'b1;
          end else begin
            state_nx = ST_EXEC;
          end
        end else begin
          state_nx = ST_HOLD;
        end
      end
      ST_EXEC: begin
        if (cnt_r == exec_last_r) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          state_nx = ST_EXEC;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Registered outputs decoded from the next state so they line up with the state register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oREADY         <= 1'b1;
      oBUSY          <= 1'b0;
      oDONE          <= 1'b0;
      LCD_EN         <= 1'b0;
      LCD_RS         <= 1'b0;
      LCD_DATA       <= 8'h00;
      low_nib_data_r <= 4'h0;
      low_nib_sent_r <= 1'b0;
      exec_last_r    <= '0;
    end else begin
      oREADY <= (state_nx == ST_IDLE);
      oBUSY  <= (state_nx != ST_IDLE);
      oDONE  <= (state_r == ST_EXEC) && (state_nx == ST_IDLE);
      LCD_EN <= (state_nx == ST_PULSE);
      if (accept_s) begin
        LCD_RS         <= iRS;
        LCD_DATA       <= (BUS_4BIT != 0) ? {iDATA[7:4], 4'h0} : iDATA;
        low_nib_data_r <= iDATA[3:0];
        low_nib_sent_r <= 1'b0;
`ifdef LCD_LONG_CMD_EN
        // Clear display / return home need the long execution wait.
        exec_last_r    <= (!iRS && (iDATA[7:2] == 6'd0)) ? LONG_LAST : EXEC_LAST;
`else
        exec_last_r    <= EXEC_LAST;
`endif
      end else if (nib_load_s) begin
        LCD_DATA       <= {low_nib_data_r, 4'h0};
        low_nib_sent_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Scoreboard bench for lcd_bus_writer: small 8-bit, small 4-bit and default-parameter instances.
`timescale 1ns/1ps
module tb_lcd_bus_writer;
  localparam int S = 1, E = 3, H = 1, X = 5, L = 20;
  localparam int D_S = 2, D_E = 12, D_H = 2, D_X = 2000, D_L = 76000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       valid [3];
  logic       rs_in [3];
  logic [7:0] data_in [3];
  logic       ready [3];
  logic       done [3];
  logic       busy [3];
  logic [7:0] lcd_data [3];
  logic       lcd_rs [3];
  logic       lcd_rw [3];
  logic       lcd_en [3];

  lcd_bus_writer #(.SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H), .EXEC_CYC(X), .LONG_CYC(L), .BUS_4BIT(0)) u_a (
    .iCLK(clk), .iRST_N(rst_n), .iVALID(valid[0]), .oREADY(ready[0]), .iRS(rs_in[0]), .iDATA(data_in[0]),
    .oDONE(done[0]), .oBUSY(busy[0]), .LCD_DATA(lcd_data[0]), .LCD_RS(lcd_rs[0]), .LCD_RW(lcd_rw[0]), .LCD_EN(lcd_en[0]));
  lcd_bus_writer #(.SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H), .EXEC_CYC(X), .LONG_CYC(L), .BUS_4BIT(1)) u_b (
    .iCLK(clk), .iRST_N(rst_n), .iVALID(valid[1]), .oREADY(ready[1]), .iRS(rs_in[1]), .iDATA(data_in[1]),
    .oDONE(done[1]), .oBUSY(busy[1]), .LCD_DATA(lcd_data[1]), .LCD_RS(lcd_rs[1]), .LCD_RW(lcd_rw[1]), .LCD_EN(lcd_en[1]));
  lcd_bus_writer u_c (
    .iCLK(clk), .iRST_N(rst_n), .iVALID(valid[2]), .oREADY(ready[2]), .iRS(rs_in[2]), .iDATA(data_in[2]),
    .oDONE(done[2]), .oBUSY(busy[2]), .LCD_DATA(lcd_data[2]), .LCD_RS(lcd_rs[2]), .LCD_RW(lcd_rw[2]), .LCD_EN(lcd_en[2]));

  typedef struct { int inst; int start; int data; int rs; int len; } strobe_t;
  typedef struct { int inst; int lat; } txn_t;

  strobe_t sq[$];
  txn_t    tq[$];
  strobe_t cur [3];
  txn_t    mon_t;
  int      cyc [3];
  int      enlen [3];
  int      lowcnt [3];
  logic    en_prev [3];
  int      dones [3];
  int      n_txn [3];
  int      n_chk = 0;
  int      n_pass = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
  endtask

  function automatic int exec_of(input int inst, input logic rs, input logic [7:0] d);
    logic is_long;
    is_long = !rs && (d[7:2] == 6'd0);
`ifndef LCD_LONG_CMD_EN
    is_long = 1'b0;
`endif
    if (inst == 2) return is_long ? D_L : D_X;
    return is_long ? L : X;
  endfunction

  task automatic push_exp(input int inst, input logic rs, input logic [7:0] d);
    int s, e, h, ex;
    strobe_t st;
    txn_t tx;
    s = (inst == 2) ? D_S : S;
    e = (inst == 2) ? D_E : E;
    h = (inst == 2) ? D_H : H;
    ex = exec_of(inst, rs, d);
    tx.inst = inst;
    if (inst == 1) begin
      st = '{inst, s, int'({d[7:4], 4'h0}), int'(rs), e};
      sq.push_back(st);
      st = '{inst, s + e + h + s, int'({d[3:0], 4'h0}), int'(rs), e};
      sq.push_back(st);
      tx.lat = 2 * (s + e + h) + ex;
    end else begin
      st = '{inst, s, int'(d), int'(rs), e};
      sq.push_back(st);
      tx.lat = s + e + h + ex;
    end
    tq.push_back(tx);
    n_txn[inst]++;
  endtask

  // Raise valid and hold it until the engine accepts (returns 1ns after the accepting edge).
  task automatic drive_accept(input int inst, input logic rs, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    valid[inst] = 1'b1;
    rs_in[inst] = rs;
    data_in[inst] = d;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (ready[inst]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int inst, input int bound);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (done[inst]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int inst, input logic rs, input logic [7:0] d, input int bound);
    push_exp(inst, rs, d);
    drive_accept(inst, rs, d);
    valid[inst] = 1'b0;
    wait_done(inst, bound);
  endtask

  // Output monitor: pops expected strobes/transactions as the bus produces them.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        cyc[i] = 0;
        enlen[i] = 0;
        lowcnt[i] = 0;
        en_prev[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        cyc[i]++;
        if (!ready[i]) lowcnt[i]++;
        chk("busy_vs_ready", int'(busy[i]), int'(!ready[i]));
        chk("rw_low", int'(lcd_rw[i]), 0);
        if (lcd_en[i] && !en_prev[i]) begin
          enlen[i] = 1;
          if (sq.size() > 0 && sq[0].inst == i) begin
            cur[i] = sq.pop_front();
            chk("strobe_cycle", cyc[i], cur[i].start);
            chk("strobe_data", int'(lcd_data[i]), cur[i].data);
            chk("strobe_rs", int'(lcd_rs[i]), cur[i].rs);
          end else begin
            chk("unexpected_strobe", i, -1);
          end
        end else if (lcd_en[i]) begin
          enlen[i]++;
        end else if (en_prev[i]) begin
          chk("en_width", enlen[i], cur[i].len);
        end
        if (done[i]) begin
          dones[i]++;
          if (tq.size() > 0 && tq[0].inst == i) begin
            mon_t = tq.pop_front();
            chk("done_latency", cyc[i], mon_t.lat);
            chk("ready_low_cycles", lowcnt[i], mon_t.lat);
            chk("done_ready", int'(ready[i]), 1);
            chk("hold_data", int'(lcd_data[i]), cur[i].data);
            chk("hold_rs", int'(lcd_rs[i]), cur[i].rs);
          end else begin
            chk("unexpected_done", i, -1);
          end
        end
        en_prev[i] = lcd_en[i];
        if (valid[i] && ready[i]) begin
          cyc[i] = -1;
          lowcnt[i] = 0;
        end
      end
    end
  end

  initial begin
    bit ok;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0;
      rs_in[i] = 1'b0;
      data_in[i] = 8'h00;
      dones[i] = 0;
      n_txn[i] = 0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", int'(ready[i]), 1);
      chk("rst_busy", int'(busy[i]), 0);
      chk("rst_done", int'(done[i]), 0);
      chk("rst_en", int'(lcd_en[i]), 0);
      chk("rst_rs", int'(lcd_rs[i]), 0);
      chk("rst_data", int'(lcd_data[i]), 0);
      chk("rst_rw", int'(lcd_rw[i]), 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single 8-bit data write; bus updates on the accepting edge.
    push_exp(0, 1'b1, 8'h41);
    drive_accept(0, 1'b1, 8'h41);
    valid[0] = 1'b0;
    chk("acc_data", int'(lcd_data[0]), 8'h41);
    chk("acc_rs", int'(lcd_rs[0]), 1);
    chk("acc_busy", int'(busy[0]), 1);
    wait_done(0, 50);

    // 4-bit instruction: two nibble strobes.
    send(1, 1'b0, 8'h38, 60);
    send(1, 1'b1, 8'hA5, 60);

    // Back-to-back with valid held high: second byte accepted in the done cycle.
    push_exp(0, 1'b1, 8'h48);
    push_exp(0, 1'b1, 8'h49);
    drive_accept(0, 1'b1, 8'h48);
    data_in[0] = 8'h49;
    drive_accept(0, 1'b1, 8'h49);
    valid[0] = 1'b0;
    wait_done(0, 50);

    // A valid pulse while busy must be dropped.
    push_exp(0, 1'b1, 8'h50);
    drive_accept(0, 1'b1, 8'h50);
    valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    valid[0] = 1'b1;
    data_in[0] = 8'h51;
    @(posedge clk);
    #1 valid[0] = 1'b0;
    wait_done(0, 50);
    repeat (5) @(posedge clk);
    #1;

    // Reset while EN is high: strobe drops at once and the transaction is lost.
    push_exp(0, 1'b1, 8'h77);
    drive_accept(0, 1'b1, 8'h77);
    valid[0] = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (lcd_en[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("en_timeout", 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_en_low", int'(lcd_en[0]), 0);
    chk("async_ready", int'(ready[0]), 1);
    tq.delete();
    n_txn[0]--;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", int'(ready[0]), 1);
    chk("post_rst_done", int'(done[0]), 0);
    repeat (15) @(posedge clk);
    #1;
    send(0, 1'b1, 8'h42, 50);

    // Clear/home versus ordinary writes of the same byte.
    send(0, 1'b0, 8'h01, 60);
    send(0, 1'b1, 8'h01, 60);
    send(1, 1'b0, 8'h02, 80);

    // Default parameters.
    send(2, 1'b1, 8'h41, 3000);

    repeat (5) @(posedge clk);
    #1;
    chk("strobes_left", sq.size(), 0);
    chk("txns_left", tq.size(), 0);
    for (int i = 0; i < 3; i++) chk("done_count", dones[i], n_txn[i]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
